antilog_offset_pipe: RTL

Pipelined log-to-linear converter for the 4b_frac PE datapath, the inverse of the log-offset lookup on the PE input side. It accepts a fixed-point log2 value, rebuilds the Mitchell mantissa `1.f`, and subtracts a 16-entry fractional offset correction. It then shifts by the integer part and returns the linear value. It sits between the PE's log-domain adder and the accumulator, and uses a valid/ready handshake on both sides.

---
 rtl/antilog_offset_pipe.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/antilog_offset_pipe.sv
// Three-stage log2-to-linear converter: capture, Mitchell mantissa with optional
// offset correction (enabled by ANTILOG_OFFSET_CORR_EN), then shift by the integer part.
module antilog_offset_pipe #(
    parameter int INT_W  = 4,
    parameter int FRAC_W = 8,
    parameter int OUT_W  = 2**INT_W + FRAC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_zero,
    input  logic [INT_W+FRAC_W-1:0] log_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        lin_out
);

    // S1: captured operand
    logic              v1_q, v1_d;
    logic [INT_W-1:0]  int1_q, int1_d;
    logic [FRAC_W-1:0] frac1_q, frac1_d;
    logic              zero1_q, zero1_d;
    // S2: mantissa
    logic              v2_q, v2_d;
    logic [INT_W-1:0]  int2_q, int2_d;
    logic [FRAC_W:0]   mant2_q, mant2_d;
    logic              zero2_q, zero2_d;
    // S3: output register
    logic              v3_q, v3_d;
    logic [OUT_W-1:0]  lin_q, lin_d;

    logic ld1, ld2, ld3;
    logic [FRAC_W:0] mant_raw;

`ifdef ANTILOG_OFFSET_CORR_EN
    // Offsets in units of 2^-8, sampled at each bin midpoint of the fraction.
    function automatic logic [7:0] corr_lut(input logic [3:0] idx);
        logic [7:0] c;
        case (idx)
            4'd0:    c = 8'd2;
            4'd1:    c = 8'd7;
            4'd2:    c = 8'd11;
            4'd3:    c = 8'd14;
            4'd4:    c = 8'd17;
            4'd5:    c = 8'd19;
            4'd6:    c = 8'd21;
            4'd7:    c = 8'd22;
            4'd8:    c = 8'd22;
            4'd9:    c = 8'd22;
            4'd10:   c = 8'd21;
            4'd11:   c = 8'd19;
            4'd12:   c = 8'd16;
            4'd13:   c = 8'd13;
            4'd14:   c = 8'd8;
            default: c = 8'd3;
        endcase
        return c;
    endfunction

    logic [FRAC_W:0] corr_ext;
    always_comb begin
        corr_ext = (FRAC_W+1)'(corr_lut(frac1_q[FRAC_W-1:FRAC_W-4])) << (FRAC_W-8);
        mant_raw = {1'b1, frac1_q} - corr_ext;
    end
`else
    always_comb mant_raw = {1'b1, frac1_q};
`endif

    // A stage may load when it is empty or its word moves on this cycle.
    always_comb begin
        ld3      = !v3_q || out_ready;
        ld2      = !v2_q || ld3;
        ld1      = !v1_q || ld2;
        in_ready = ld1;
    end

    always_comb begin
        v1_d    = v1_q;
        int1_d  = int1_q;
        frac1_d = frac1_q;
        zero1_d = zero1_q;
        if (ld1) begin
            v1_d = in_valid;
            if (in_valid) begin
                int1_d  = log_in[INT_W+FRAC_W-1:FRAC_W];
                frac1_d = log_in[FRAC_W-1:0];
                zero1_d = in_zero;
            end
        end
    end

    always_comb begin
        v2_d    = v2_q;
        int2_d  = int2_q;
        mant2_d = mant2_q;
        zero2_d = zero2_q;
        if (ld2) begin
            v2_d = v1_q;
            if (v1_q) begin
                int2_d  = int1_q;
                mant2_d = mant_raw;
                zero2_d = zero1_q;
            end
        end
    end

    always_comb begin
        v3_d  = v3_q;
        lin_d = lin_q;
        if (ld3) begin
            v3_d = v2_q;
            if (v2_q)
                lin_d = zero2_q ? '0 : (OUT_W'(mant2_q) << int2_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            int1_q  <= '0;
            frac1_q <= '0;
            zero1_q <= 1'b0;
            v2_q    <= 1'b0;
            int2_q  <= '0;
            mant2_q <= '0;
            zero2_q <= 1'b0;
            v3_q    <= 1'b0;
            lin_q   <= '0;
        end else begin
            v1_q    <= v1_d;
            int1_q  <= int1_d;
            frac1_q <= frac1_d;
            zero1_q <= zero1_d;
            v2_q    <= v2_d;
            int2_q  <= int2_d;
            mant2_q <= mant2_d;
            zero2_q <= zero2_d;
            v3_q    <= v3_d;
            lin_q   <= lin_d;
        end
    end

    assign out_valid = v3_q;
    assign lin_out   = lin_q;

endmodule
